scurve_velocity_ctrl: RTL and testbench
=======================================

// Module: scurve_velocity_ctrl
// PURPOSE
//   Jerk-limited (S-curve) velocity profile sequencer. On a start command it
//   ramps an internal velocity register from its current value to a target
//   through jerk-up, constant-accel and jerk-down phases, one update per
//   profile tick. Its output feeds the step-rate generator and the 3-digit
//   seven-segment display path of the top-level led design.
// PARAMETERS
//   VEL_W     16    velocity width (unsigned magnitude)
//   ACC_W     12    acceleration magnitude width
//   JERK      1     acceleration change per tick (>=1)
//   ACC_MAX   16    acceleration ceiling (>=JERK, < 2**ACC_W)
//   TICK_DIV  1000  clocks per profile tick (>=2)
// PORTS
//   Clk          in   1      system clock
//   Rst_n        in   1      asynchronous active-low reset
//   i_Start      in   1      1-clk pulse: begin ramp to i_TargetVel
//   i_TargetVel  in   VEL_W  target velocity, sampled only when i_Start accepted
//   i_Abort      in   1      1-clk pulse: stop ramp, hold current velocity
//   o_Vel        out  VEL_W  current commanded velocity
//   o_Acc        out  ACC_W  current acceleration magnitude
//   o_Dir        out  1      0 = ramping up, 1 = ramping down
//   o_Phase      out  3      0 IDLE, 1 JERK_UP, 2 ACC_HOLD, 3 JERK_DOWN
//   o_Busy       out  1      high while phase != IDLE
//   o_Done       out  1      1-clk pulse when target reached
// BEHAVIOUR
//   - Reset (async, Rst_n=0): o_Vel=0, o_Acc=0, o_Dir=0, o_Phase=IDLE,
//     o_Busy=0, o_Done=0, tick counter=0, dv_up=0, target latch=0.
//   - Start accepted only in IDLE; i_Start while busy is ignored. i_Abort wins
//     over i_Start in the same cycle.
//   - On accept: latch target, o_Dir = (target < o_Vel), acc=0, dv_up=0,
//     tick counter cleared; phase=JERK_UP next clk. If target == o_Vel:
//     stay IDLE, o_Done pulses the next clk, o_Vel unchanged.
//   - Tick fires every TICK_DIV clks while busy; first tick TICK_DIV clks after
//     accept. All updates below happen on the tick clk only. rem=|target-vel|.
//   - JERK_UP: acc'=min(acc+JERK,ACC_MAX); step=acc'; dv_up+=acc'.
//       step>=rem -> vel=target, DONE. Else vel+=/-step; then
//       rem-step<=dv_up' -> JERK_DOWN; elif acc'==ACC_MAX -> ACC_HOLD.
//   - ACC_HOLD: step=acc. step>=rem -> vel=target, DONE. Else vel+=/-step;
//       rem-step<=dv_up -> JERK_DOWN.
//   - JERK_DOWN: acc'=max(acc-JERK,JERK) (floor guarantees termination);
//       step=acc'. step>=rem -> vel=target, DONE. Else vel+=/-step.
//   - DONE: on the same tick clk set acc=0, phase=IDLE; o_Done high for the
//     following clk only. o_Vel never overshoots or wraps the target.
//   - Abort (any busy phase): next clk acc=0, phase=IDLE, o_Vel held, no o_Done.
//   - Arithmetic in VEL_W+1 bits internally; dv_up saturates at 2**VEL_W-1.
//   - Reset mid-ramp returns all outputs to reset values immediately.
// TESTING  (bench params: JERK=1, ACC_MAX=4, TICK_DIV=2)
//   1 Start 0->20: o_Vel per tick 1,3,6,10,13,15,16,17,18,19,20;
//     o_Phase 1,1,1,3..3; o_Done one clk after 11th tick (22 clks).
//   2 From 20, start to 0: o_Dir=1, o_Vel 19,17,14,10,7,5,4,3,2,1,0; o_Done once.
//   3 Start 0->100: reaches o_Acc=4 -> o_Phase=2 (ACC_HOLD), then JERK_DOWN;
//     final o_Vel=100 exactly, never >100.
//   4 Start with target==o_Vel (e.g. 0->0): o_Busy stays 0, o_Done pulse next clk.
//   5 Abort after tick 3 of 0->20: o_Vel holds 6, o_Acc=0, o_Busy=0, no o_Done;
//     i_Start while busy ignored (target unchanged, sequence as in 1).
//   6 Rst_n low mid-ramp (async, between clk edges): all outputs 0 at once;
//     new Start 0->20 after release repeats sequence 1.

Source files
------------

// File: rtl/scurve_velocity_ctrl.sv
// scurve_velocity_ctrl: jerk-limited S-curve velocity ramp sequencer
module scurve_velocity_ctrl #(
    parameter int VEL_W    = 16,
    parameter int ACC_W    = 12,
    parameter int JERK     = 1,
    parameter int ACC_MAX  = 16,
    parameter int TICK_DIV = 1000
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             i_Start,
    input  logic [VEL_W-1:0] i_TargetVel,
    input  logic             i_Abort,
    output logic [VEL_W-1:0] o_Vel,
    output logic [ACC_W-1:0] o_Acc,
    output logic             o_Dir,
    output logic [2:0]       o_Phase,
    output logic             o_Busy,
    output logic             o_Done
);
    typedef enum logic [2:0] {IDLE = 3'd0, JERK_UP = 3'd1, ACC_HOLD = 3'd2, JERK_DOWN = 3'd3} phase_t;
    localparam int CNT_W = $clog2(TICK_DIV);
    phase_t phase, phase_n;
    logic [VEL_W-1:0] vel, vel_n, target, target_n, dv_up, dv_up_n, dv_new, dv_cmp, vel_step;
    logic [ACC_W-1:0] acc, acc_n, acc_up, acc_dn, acc_sel;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [VEL_W:0]   rem, step, rem_left, dv_sum;
    logic             dir, dir_n, done, done_n, tick, reach;
    assign tick     = (phase != IDLE) && (cnt == CNT_W'(TICK_DIV - 1));
    assign acc_up   = (acc >= ACC_W'(ACC_MAX - JERK)) ? ACC_W'(ACC_MAX) : acc + ACC_W'(JERK);
    assign acc_dn   = (acc >= ACC_W'(2 * JERK)) ? acc - ACC_W'(JERK) : ACC_W'(JERK);
    assign acc_sel  = (phase == JERK_UP) ? acc_up : (phase == JERK_DOWN) ? acc_dn : acc;
    assign step     = (VEL_W + 1)'(acc_sel);
    assign rem      = dir ? {1'b0, vel} - {1'b0, target} : {1'b0, target} - {1'b0, vel};
    assign rem_left = rem - step;
    assign reach    = step >= rem;
    assign dv_sum   = {1'b0, dv_up} + step;
    assign dv_new   = dv_sum[VEL_W] ? '1 : dv_sum[VEL_W-1:0];
    assign dv_cmp   = (phase == JERK_UP) ? dv_new : dv_up;
    assign vel_step = dir ? vel - step[VEL_W-1:0] : vel + step[VEL_W-1:0];
    // state and datapath registers; reset clears everything immediately
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            phase  <= IDLE;
            vel    <= '0;
            acc    <= '0;
            dir    <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            dv_up  <= '0;
            target <= '0;
        end else begin
            phase  <= phase_n;
            vel    <= vel_n;
            acc    <= acc_n;
            dir    <= dir_n;
            done   <= done_n;
            cnt    <= cnt_n;
            dv_up  <= dv_up_n;
            target <= target_n;
        end
    end
    // next-state: abort beats start; profile updates only on the tick clock
    always_comb begin
        phase_n  = phase;
        vel_n    = vel;
        acc_n    = acc;
        dir_n    = dir;
        done_n   = 1'b0;
        dv_up_n  = dv_up;
        target_n = target;
        cnt_n    = tick ? '0 : (phase != IDLE) ? cnt + 1'b1 : cnt;
        if (i_Abort) begin
            phase_n = IDLE;
            acc_n   = (phase != IDLE) ? '0 : acc;
        end else if (phase == IDLE) begin
            if (i_Start) begin
                target_n = i_TargetVel;
                dir_n    = i_TargetVel < vel;
                acc_n    = '0;
                dv_up_n  = '0;
                cnt_n    = '0;
                done_n   = i_TargetVel == vel;
                phase_n  = (i_TargetVel == vel) ? IDLE : JERK_UP;
            end
        end else if (tick) begin
            acc_n   = reach ? '0 : acc_sel;
            dv_up_n = (phase == JERK_UP) ? dv_new : dv_up;
            vel_n   = reach ? target : vel_step;
            done_n  = reach;
            if (reach)
                phase_n = IDLE;
            else if (phase != JERK_DOWN && rem_left <= {1'b0, dv_cmp})
                phase_n = JERK_DOWN;
            else if (phase == JERK_UP && acc_up == ACC_W'(ACC_MAX))
                phase_n = ACC_HOLD;
        end
    end
    assign o_Vel   = vel;
    assign o_Acc   = acc;
    assign o_Dir   = dir;
    assign o_Phase = phase;
    assign o_Busy  = phase != IDLE;
    assign o_Done  = done;
endmodule

// File: tb/tb_scurve_velocity_ctrl.sv
// tb_scurve_velocity_ctrl: directed scoreboard bench for the S-curve sequencer
module tb_scurve_velocity_ctrl;
    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        i_Start = 1'b0;
    logic [15:0] i_TargetVel = '0;
    logic        i_Abort = 1'b0;
    logic [15:0] o_Vel;
    logic [11:0] o_Acc;
    logic        o_Dir;
    logic [2:0]  o_Phase;
    logic        o_Busy;
    logic        o_Done;
    typedef struct {int vel; int phase;} exp_t;
    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int seq_up[11]   = '{1, 3, 6, 10, 13, 15, 16, 17, 18, 19, 20};
    int seq_dn[11]   = '{19, 17, 14, 10, 7, 5, 4, 3, 2, 1, 0};
    int seq_ph[11]   = '{1, 1, 1, 3, 3, 3, 3, 3, 3, 3, 0};

    scurve_velocity_ctrl #(.VEL_W(16), .ACC_W(12), .JERK(1), .ACC_MAX(4), .TICK_DIV(2)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .i_Start(i_Start), .i_TargetVel(i_TargetVel), .i_Abort(i_Abort),
        .o_Vel(o_Vel), .o_Acc(o_Acc), .o_Dir(o_Dir), .o_Phase(o_Phase), .o_Busy(o_Busy), .o_Done(o_Done)
    );

    always #5 Clk = ~Clk;

    // counts every o_Done pulse seen at a clock edge
    always @(posedge Clk) if (o_Done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int tgt);
        i_Start = 1'b1;
        i_TargetVel = 16'(tgt);
        @(posedge Clk);
        @(negedge Clk);
        i_Start = 1'b0;
    endtask

    task automatic push_seq(input int dn);
        for (int i = 0; i < 11; i++) exp_q.push_back('{dn ? seq_dn[i] : seq_up[i], seq_ph[i]});
    endtask

    task automatic run_ticks(input string tag, input int inject);
        exp_t e;
        int k = 0;
        while (exp_q.size() > 0) begin
            if (inject != 0 && k == 1) begin
                i_Start = 1'b1;
                i_TargetVel = 16'd50;
                @(posedge Clk);
                @(negedge Clk);
                i_Start = 1'b0;
                @(posedge Clk);
            end else begin
                repeat (2) @(posedge Clk);
            end
            @(negedge Clk);
            e = exp_q.pop_front();
            check({tag, "_vel"}, int'(o_Vel), e.vel);
            check({tag, "_phase"}, int'(o_Phase), e.phase);
            k++;
        end
    endtask

    task automatic full_ramp(input string tag, input int dn, input int inject);
        int d0;
        d0 = done_cnt;
        do_start(dn ? 0 : 20);
        check({tag, "_dir"}, int'(o_Dir), dn);
        check({tag, "_busy"}, int'(o_Busy), 1);
        push_seq(dn);
        run_ticks(tag, inject);
        check({tag, "_done_hi"}, int'(o_Done), 1);
        check({tag, "_acc0"}, int'(o_Acc), 0);
        @(negedge Clk);
        check({tag, "_done_lo"}, int'(o_Done), 0);
        check({tag, "_idle"}, int'(o_Busy), 0);
        repeat (3) @(negedge Clk);
        check({tag, "_done_once"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        int maxv;
        int saw_hold;
        int jd_after_hold;
        int saw_acc4;
        int finished;
        repeat (2) @(negedge Clk);
        check("rst_vel", int'(o_Vel), 0);
        check("rst_acc", int'(o_Acc), 0);
        check("rst_phase", int'(o_Phase), 0);
        check("rst_busy", int'(o_Busy), 0);
        check("rst_done", int'(o_Done), 0);
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);

        full_ramp("up", 0, 1);
        full_ramp("down", 1, 0);

        d0 = done_cnt;
        do_start(0);
        check("eq_busy", int'(o_Busy), 0);
        check("eq_done_hi", int'(o_Done), 1);
        check("eq_vel", int'(o_Vel), 0);
        @(negedge Clk);
        check("eq_done_lo", int'(o_Done), 0);
        check("eq_busy2", int'(o_Busy), 0);

        d0 = done_cnt;
        do_start(20);
        exp_q.push_back('{1, 1});
        exp_q.push_back('{3, 1});
        exp_q.push_back('{6, 1});
        run_ticks("abort", 0);
        i_Abort = 1'b1;
        @(negedge Clk);
        i_Abort = 1'b0;
        check("abort_vel", int'(o_Vel), 6);
        check("abort_acc", int'(o_Acc), 0);
        check("abort_busy", int'(o_Busy), 0);
        repeat (6) @(negedge Clk);
        check("abort_hold", int'(o_Vel), 6);
        check("abort_nodone", done_cnt - d0, 0);

        do_start(0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("pre_rst_vel", int'(o_Vel), 5);
        #2 Rst_n = 1'b0;
        #1;
        check("arst_vel", int'(o_Vel), 0);
        check("arst_acc", int'(o_Acc), 0);
        check("arst_dir", int'(o_Dir), 0);
        check("arst_phase", int'(o_Phase), 0);
        check("arst_busy", int'(o_Busy), 0);
        check("arst_done", int'(o_Done), 0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        full_ramp("after_rst", 0, 0);

        d0 = done_cnt;
        maxv = 0;
        saw_hold = 0;
        jd_after_hold = 0;
        saw_acc4 = 0;
        finished = 0;
        do_start(100);
        for (int c = 0; c < 1000 && finished == 0; c++) begin
            @(negedge Clk);
            if (int'(o_Vel) > maxv) maxv = int'(o_Vel);
            if (o_Acc == 12'd4) saw_acc4 = 1;
            if (o_Phase == 3'd2) saw_hold = 1;
            if (o_Phase == 3'd3 && saw_hold != 0) jd_after_hold = 1;
            if (o_Done === 1'b1) finished = 1;
        end
        check("long_finished", finished, 1);
        check("long_vel", int'(o_Vel), 100);
        check("long_no_overshoot", maxv, 100);
        check("long_acc4", saw_acc4, 1);
        check("long_hold", saw_hold, 1);
        check("long_jd_after_hold", jd_after_hold, 1);
        repeat (3) @(negedge Clk);
        check("long_done_once", done_cnt - d0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
